// File: rtl/i2s_master_tx.sv
// I2S master transmitter: accepts 24-bit L/R sample pairs via valid/ready and
// drives sclk/ws/data as a 64-bit-per-frame standard I2S stream.
module i2s_master_tx #(
    parameter int SCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] lft_smpl,
    input  logic [23:0] rght_smpl,
    input  logic        smpl_vld,
    output logic        smpl_rdy,
    output logic        I2S_sclk,
    output logic        I2S_ws,
    output logic        I2S_data,
    output logic        frm_strt,
    output logic        underrun,
    output logic        dbg_state_o
);

    localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        first_q, first_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic        ws_q, ws_d;
    logic        data_q, data_d;
    logic        frm_q, frm_d;
    logic        und_q, und_d;
    logic        hold_full_q, hold_full_d;
    logic [23:0] hold_l_q, hold_l_d;
    logic [23:0] hold_r_q, hold_r_d;
    logic [23:0] shl_q, shl_d;
    logic [23:0] shr_q, shr_d;

    logic        accept;
    logic        tc;
    logic        fall;
    logic [5:0]  nb;
    logic [4:0]  idx;

    // Handshake: a pair moves into holding on any clk where smpl_vld && smpl_rdy;
    // smpl_rdy is simply "holding empty" and never depends on smpl_vld.
    assign accept = smpl_vld & ~hold_full_q;
    assign tc     = (div_q == DIV_W'(SCLK_DIV - 1));
    assign fall   = (state_q == RUN) && tc && sclk_q;
    // The first fall after leaving IDLE lands on b=63 rather than advancing.
    assign nb     = first_q ? 6'd63 : bit_q + 6'd1;
    // Left bit b and right bit b+32 share the same word index 23-b.
    assign idx    = 5'd23 - nb[4:0];

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        ws_d        = ws_q;
        data_d      = data_q;
        frm_d       = 1'b0;
        und_d       = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        shl_d       = shl_q;
        shr_d       = shr_q;

        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = lft_smpl;
            hold_r_d    = rght_smpl;
        end

        case (state_q)
            IDLE: begin
                div_d   = '0;
                bit_d   = 6'd0;
                sclk_d  = 1'b0;
                ws_d    = 1'b1;
                data_d  = 1'b0;
                first_d = 1'b1;
                if (en) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                div_d = tc ? '0 : div_q + DIV_W'(1);
                if (tc) begin
                    sclk_d = ~sclk_q;
                end
                if (fall) begin
                    if (nb == 6'd63 && !en) begin
                        // Stop only between frames; holding data stays put.
                        state_d = IDLE;
                        first_d = 1'b1;
                        bit_d   = 6'd0;
                        ws_d    = 1'b1;
                        data_d  = 1'b0;
                    end else begin
                        first_d = 1'b0;
                        bit_d   = nb;
                        ws_d    = (nb >= 6'd31) && (nb <= 6'd62);
                        frm_d   = (nb == 6'd0);
                        if (nb <= 6'd23) begin
                            data_d = shl_q[idx];
                        end else if (nb >= 6'd32 && nb <= 6'd55) begin
                            data_d = shr_q[idx];
                        end else begin
                            data_d = 1'b0;
                        end

                        if (nb == 6'd63) begin
                            if (hold_full_q) begin
                                shl_d       = hold_l_q;
                                shr_d       = hold_r_q;
                                hold_full_d = 1'b0;
                            end else if (smpl_vld) begin
                                // Late arrival goes straight to the shifters.
                                shl_d       = lft_smpl;
                                shr_d       = rght_smpl;
                                hold_full_d = 1'b0;
                            end else begin
                                shl_d = '0;
                                shr_d = '0;
                                und_d = 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            first_q     <= 1'b1;
            div_q       <= '0;
            bit_q       <= 6'd0;
            sclk_q      <= 1'b0;
            ws_q        <= 1'b1;
            data_q      <= 1'b0;
            frm_q       <= 1'b0;
            und_q       <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shl_q       <= '0;
            shr_q       <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            ws_q        <= ws_d;
            data_q      <= data_d;
            frm_q       <= frm_d;
            und_q       <= und_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
        end
    end

    assign smpl_rdy    = ~hold_full_q;
    assign I2S_sclk    = sclk_q;
    assign I2S_ws      = ws_q;
    assign I2S_data    = data_q;
    assign frm_strt    = frm_q;
    assign underrun    = und_q;
    assign dbg_state_o = (state_q == RUN);

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

I2S master transmitter. It takes parallel 24-bit left/right audio samples through a valid/ready handshake and serialises them onto `I2S_sclk`, `I2S_ws` and `I2S_data`. It generates all three I2S lines itself from `clk`, so it is the transmitting end of the link that the equalizer's I2S slave receives. It serves as the on-chip source for loopback and self-test, and as the BT-audio stimulus in full-chip benches.

## Interface
Parameters:
- `SCLK_DIV`, default 16: `clk` cycles per `I2S_sclk` half-period. Must be ≥2. Default gives 1.5625 MHz sclk and a 24.4 kHz frame at 50 MHz.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable. Acted on only at frame boundaries.
- `lft_smpl`  in  24  left sample, two's complement.
- `rght_smpl`  in  24  right sample, two's complement.
- `smpl_vld`  in  1  sample pair valid.
- `smpl_rdy`  out  1  holding register empty. Equals `~hold_full`.
- `I2S_sclk`  out  1  bit clock. Registered.
- `I2S_ws`  out  1  word select: 0 = left, 1 = right. Registered.
- `I2S_data`  out  1  serial data, MSB first. Registered.
- `frm_strt`  out  1  1-clk pulse when the left MSB is driven.
- `underrun`  out  1  1-clk pulse when a frame starts with no sample available.

## Operation
- Reset values:
  - `I2S_sclk`=0, `I2S_ws`=1, `I2S_data`=0.
  - `frm_strt`=0, `underrun`=0.
  - `hold_full`=0, so `smpl_rdy`=1.
  - State IDLE; `div_cnt`=0, `bit_cnt`=0.
- Handshake:
  - A sample pair is accepted into the holding register when `smpl_vld & smpl_rdy`.
  - Accepted data is not changed until it is transferred.
- Divider:
  - In RUN, `div_cnt` counts 0..SCLK_DIV-1.
  - At terminal count, `I2S_sclk` toggles and `div_cnt` wraps to 0.
  - A "fall event" is terminal count while `I2S_sclk`=1.
  - `I2S_ws` and `I2S_data` change only on the clk edge of a fall event.
- Bit counter: `bit_cnt` (6 bits) advances on each fall event, 63 wrapping to 0. Per `bit_cnt` value b:
  - b=63: `I2S_ws`=0, `I2S_data`=0.
  - b=0..23: `I2S_ws`=0, `I2S_data`=L[23-b].
  - b=24..30: `I2S_ws`=0, `I2S_data`=0.
  - b=31: `I2S_ws`=1, `I2S_data`=0.
  - b=32..55: `I2S_ws`=1, `I2S_data`=R[55-b].
  - b=56..62: `I2S_ws`=1, `I2S_data`=0.
  - This gives standard I2S: ws leads MSB by one sclk, and the receiver samples on the sclk rising edge.
- Transfer:
  - On the fall event that enters b=63, holding moves to the shift registers (L, R) and `hold_full` clears.
  - If holding is empty, L=R=0 and `underrun` pulses.
  - If `smpl_vld` is high in that same clk while holding is empty, that pair bypasses directly into L/R. No underrun is flagged, and holding stays empty.
- States:
  - IDLE:
    - Outputs are held at their reset values and the counters are cleared.
    - The handshake stays live, so one pair can be pre-loaded.
    - IDLE→RUN when `en`=1.
  - RUN→RUN:
    - The first fall event after entry sets b=63.
    - It then cycles continuously.
  - RUN→IDLE:
    - Taken at the fall event that would enter b=63 while `en`=0.
    - `I2S_ws` stays 1, `I2S_data` 0, sclk is now 0, and no transfer occurs.
    - A frame in progress always completes.
- `frm_strt` pulses on the fall event that enters b=0.
- Reset mid-operation: all state is cleared immediately and asynchronously, and any pending holding data is discarded.

## Timing
- One sclk period is 2·SCLK_DIV clks; one frame is 128·SCLK_DIV clks.
- IDLE→RUN: first sclk rise occurs SCLK_DIV clks after `en` is sampled high; the first fall event (b=63) occurs 2·SCLK_DIV clks after.
- The first left MSB appears 4·SCLK_DIV clks after `en` is sampled high.
- Transfer latency: a sample accepted at least 1 clk before the b=63 fall event has its left MSB on `I2S_data` one sclk period later.
- `smpl_rdy` rises 1 clk after the transfer edge.
- At most one pair is buffered; `smpl_rdy` stays low for the rest of the frame.

## Test plan
- Basic frame:
  - Stimulus: SCLK_DIV=4, preload L=24'hA50F3C / R=24'h123456, `en`=1.
  - Response: receiver sampling on sclk rise captures A50F3C with ws=0 and 123456 with ws=1, and all padding bits are 0.
  - Response: `frm_strt` occurs 16 clks after `en`.
- Back-to-back:
  - Stimulus: keep `smpl_vld`=1 with incrementing data.
  - Response: exactly one pair is accepted per 512-clk frame, and `smpl_rdy` is low between transfers.
  - Response: no `underrun`, and frames are received in order.
- Underrun:
  - Stimulus: stop supplying data after 2 frames.
  - Response: the third frame is all zeros, and `underrun` pulses once at its b=63 edge.
- Same-cycle bypass:
  - Stimulus: assert `smpl_vld` only in the clk of the b=63 fall event, with holding empty.
  - Response: that pair is transmitted in the following frame, and there is no `underrun`.
- Enable drop:
  - Stimulus: deassert `en` at b=10.
  - Response: the frame completes through b=62, then IDLE with sclk=0, ws=1, data=0.
  - Response: re-asserting `en` restarts with the 16-clk latency.
- Reset mid-frame:
  - Stimulus: assert `rst` at b=40 with holding full.
  - Response: all outputs take their reset values immediately, `smpl_rdy`=1, and the old data is never transmitted.
